// File: rtl/core_seq_if.sv
// Instruction bus between the tile sequencer and core.
// Carries inst, SRAM/psum mode selects and the OFIFO-ready flag.
interface core_seq_if #(
  parameter int pmem_index = 11
);
  logic [22+pmem_index:0] inst;
  logic                   xw_mode;
  logic                   pmem_mode;
  logic                   ofifo_valid;

  modport master (
    output inst,
    output xw_mode,
    output pmem_mode,
    input  ofifo_valid
  );

  modport slave (
    input  inst,
    input  xw_mode,
    input  pmem_mode,
    output ofifo_valid
  );
endinterface

// File: rtl/core_seq.sv
// Tile-pass sequencer: weight load, kernel load, activation
// stream, execute and OFIFO drain into psum memory.
module core_seq #(
  parameter int row        = 8,
  parameter int col        = 8,
  parameter int pmem_index = 11,
  parameter int xmem_index = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [xmem_index-1:0] w_base,
  input  logic [xmem_index-1:0] x_base,
  input  logic [pmem_index-1:0] p_base,
  input  logic [xmem_index-1:0] len,
  core_seq_if.master            bus,
  output logic                  busy,
  output logic                  done
);

  localparam int IW = 23 + pmem_index;
  localparam logic [IW-1:0] IDLE_INST = IW'(12'hF00);
  localparam logic [xmem_index-1:0] ONE = xmem_index'(1);
  localparam logic [xmem_index-1:0] WRD_LAST =
    xmem_index'(row - 1);
  localparam logic [xmem_index-1:0] WLD_LAST =
    xmem_index'(row + col - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRD,
    S_WLOAD,
    S_XRD,
    S_EXEC,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_d;

  logic [xmem_index-1:0] cnt, cnt_d;
  logic [xmem_index-1:0] rd_cnt, rd_d;
  logic [xmem_index-1:0] wr_cnt, wr_d;
  logic [xmem_index-1:0] w_q, x_q, len_q;
  logic [pmem_index-1:0] p_q;
  logic [xmem_index-1:0] lm1;

  logic [IW-1:0] inst_q, inst_d;
  logic          xw_q, xw_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  assign lm1 = len_q - ONE;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rd_d    = rd_cnt;
    wr_d    = wr_cnt;
    inst_d  = IDLE_INST;
    xw_d    = 1'b0;
    busy_d  = (state != S_IDLE);
    done_d  = (state == S_DONE);

    // SRAM data and OFIFO data land one cycle after their request
    inst_d[0] = ~inst_q[9];
    if (inst_q[4]) begin
      inst_d[10]       = 1'b0;
      inst_d[11]       = 1'b0;
      inst_d[IW-1:23]  = p_q + pmem_index'(wr_cnt);
      wr_d             = wr_cnt + ONE;
    end

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_d = (len == '0) ? S_DONE : S_WRD;
          cnt_d   = '0;
          rd_d    = '0;
          wr_d    = '0;
        end
      end
      S_WRD: begin
        xw_d          = 1'b1;
        inst_d[9]     = 1'b0;
        inst_d[22:12] = w_q + cnt;
        if (cnt == WRD_LAST) begin
          state_d = S_WLOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      S_WLOAD: begin
        xw_d      = 1'b1;
        inst_d[1] = 1'b1;
        inst_d[5] = 1'b1;
        if (cnt == WLD_LAST) begin
          state_d = S_XRD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      S_XRD: begin
        inst_d[9]     = 1'b0;
        inst_d[22:12] = x_q + cnt;
        if (cnt == lm1) begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      S_EXEC: begin
        inst_d[1] = 1'b1;
        inst_d[6] = 1'b1;
        if (cnt == lm1) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      S_DRAIN: begin
        if (bus.ofifo_valid && rd_cnt < len_q) begin
          inst_d[4] = 1'b1;
          rd_d      = rd_cnt + ONE;
        end
        if (inst_q[4] && wr_cnt == lm1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      w_q    <= '0;
      x_q    <= '0;
      p_q    <= '0;
      len_q  <= '0;
      inst_q <= IDLE_INST;
      xw_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      rd_cnt <= rd_d;
      wr_cnt <= wr_d;
      inst_q <= inst_d;
      xw_q   <= xw_d;
      busy_q <= busy_d;
      done_q <= done_d;
      if (state == S_IDLE && start) begin
        w_q   <= w_base;
        x_q   <= x_base;
        p_q   <= p_base;
        len_q <= len;
      end
    end
  end

  assign bus.inst      = inst_q;
  assign bus.xw_mode   = xw_q;
  assign bus.pmem_mode = 1'b0;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_core_seq.sv
// Randomized bench for core_seq against an address-list
// model of one tile pass.
module tb_core_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] w_base, x_base, p_base, len;
  logic        busy, done;

  core_seq_if #(.pmem_index(11)) bus ();

  core_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .w_base (w_base),
    .x_base (x_base),
    .p_base (p_base),
    .len    (len),
    .bus    (bus),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  int vmode = 0;
  initial begin
    bus.ofifo_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (vmode)
        0: bus.ofifo_valid = 1'b1;
        1: bus.ofifo_valid = ~bus.ofifo_valid;
        default: bus.ofifo_valid = 1'($urandom_range(0, 1));
      endcase
    end
  end

  bit          mon_en = 0;
  int          cyc = 0, st_cyc = 0, done_cyc = 0;
  int          n_l0wr, n_load, n_exec, n_ordd;
  int          n_done, n_busy, ld_first, ld_last;
  logic [11:0] xa[$];
  logic [10:0] pa[$];
  logic        p_cen0 = 1'b0, p_ordd = 1'b0, p_valid = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (start) st_cyc = cyc;
    if (mon_en) begin
      chk("l0_wr_lag", bus.inst[0], p_cen0);
      chk("pmem_wr_lag", {~bus.inst[11], ~bus.inst[10]},
          {p_ordd, p_ordd});
      if (bus.inst[4]) chk("ofifo_rd_valid", p_valid, 1);
      chk("fixed_bits",
          {bus.inst[2], bus.inst[3], bus.inst[7],
           bus.inst[8], bus.pmem_mode}, 5'b00010);
      if (!bus.inst[9])
        xa.push_back({bus.xw_mode, bus.inst[22:12]});
      if (!bus.inst[11]) pa.push_back(bus.inst[33:23]);
      if (bus.inst[0]) n_l0wr++;
      if (bus.inst[5]) begin
        if (n_load == 0) ld_first = cyc;
        ld_last = cyc;
        n_load++;
      end
      if (bus.inst[6]) n_exec++;
      if (bus.inst[4]) n_ordd++;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (busy) n_busy++;
    end
    p_cen0  = ~bus.inst[9];
    p_ordd  = bus.inst[4];
    p_valid = bus.ofifo_valid;
  end

  task automatic run_pass(input logic [10:0] w,
                          input logic [10:0] x,
                          input logic [10:0] p,
                          input logic [10:0] l,
                          input int vm,
                          input bit restart);
    logic [11:0] ex[$];
    logic [10:0] ep[$];
    logic [10:0] a;
    bit ok, did;
    int nl;
    nl = int'(l);
    ex.delete();
    ep.delete();
    if (nl > 0) begin
      for (int i = 0; i < 8; i++) begin
        a = w + 11'(i);
        ex.push_back({1'b1, a});
      end
      for (int i = 0; i < nl; i++) begin
        a = x + 11'(i);
        ex.push_back({1'b0, a});
      end
      for (int k = 0; k < nl; k++) begin
        a = p + 11'(k);
        ep.push_back(a);
      end
    end
    xa.delete();
    pa.delete();
    n_l0wr = 0; n_load = 0; n_exec = 0; n_ordd = 0;
    n_done = 0; n_busy = 0; ld_first = 0; ld_last = -1;
    vmode  = vm;
    mon_en = 1;
    @(posedge clk); #1;
    w_base = w; x_base = x; p_base = p; len = l;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    w_base = 11'($urandom); x_base = 11'($urandom);
    p_base = 11'($urandom); len = 11'($urandom);
    ok = 0; did = 0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (n_done > 0) begin
        ok = 1;
        break;
      end
      if (restart && !did && n_load > 2) begin
        start = 1'b1;
        did   = 1;
      end
    end
    start = 1'b0;
    chk("done_seen", ok, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("busy_after", busy, 0);
    mon_en = 0;
    chk("done_count", n_done, 1);
    chk("xmem_reads", xa.size(), ex.size());
    for (int i = 0; i < xa.size() && i < ex.size(); i++)
      chk("xmem_addr", xa[i], ex[i]);
    chk("psum_writes", pa.size(), ep.size());
    for (int i = 0; i < pa.size() && i < ep.size(); i++)
      chk("psum_addr", pa[i], ep[i]);
    chk("l0_wr_count", n_l0wr, (nl > 0) ? 8 + nl : 0);
    chk("load_count", n_load, (nl > 0) ? 16 : 0);
    if (nl > 0) chk("load_span", ld_last - ld_first + 1, 16);
    chk("exec_count", n_exec, nl);
    chk("ofifo_rd_count", n_ordd, nl);
    if (nl == 0) begin
      chk("len0_done_lat", done_cyc - st_cyc, 2);
      chk("len0_busy", n_busy, 1);
    end
  endtask

  initial begin
    bit ok;
    reset = 1'b1;
    start = 1'b0;
    w_base = '0; x_base = '0; p_base = '0; len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_inst", bus.inst, 34'h0_0000_0F00);
    chk("rst_flags", {busy, done, bus.xw_mode}, 3'b000);
    @(posedge clk); #1;
    reset = 1'b0;

    run_pass(11'h010, 11'h100, 11'h020, 11'd4, 0, 0);
    run_pass(11'h010, 11'h100, 11'h020, 11'd4, 1, 0);
    run_pass(11'h033, 11'h044, 11'h055, 11'd0, 0, 0);
    run_pass(11'h010, 11'h100, 11'h020, 11'd4, 0, 1);
    run_pass(11'h3F8, 11'h7FE, 11'h7FF, 11'd3, 1, 0);

    @(posedge clk); #1;
    w_base = 11'h0A0; x_base = 11'h0B0;
    p_base = 11'h0C0; len = 11'd5;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.inst[6]) begin
        ok = 1;
        break;
      end
    end
    chk("exec_reached", ok, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_inst", bus.inst, 34'h0_0000_0F00);
    chk("midrst_flags", {busy, done, bus.xw_mode}, 3'b000);
    run_pass(11'h0A0, 11'h0B0, 11'h0C0, 11'd5, 0, 0);

    for (int r = 0; r < 4; r++)
      run_pass(11'($urandom), 11'($urandom),
               11'($urandom), 11'($urandom_range(1, 6)),
               2, bit'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
